// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between a core port (C) and a debug/DMA port (D)
// Ports: i_clk, i_rst (async, active-high); core i_c_req/we/addr/wdata -> o_c_gnt/rvalid/rdata;
// debug i_d_req/we/lock/addr/wdata -> o_d_gnt/rvalid/rdata; memory o_m_we/addr/wdata <- i_m_rdata;
// o_starved pulses when D wins only because it has waited STARVE_MAX cycles.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_c_req,
    input  logic          i_c_we,
    input  logic [AW-1:0] i_c_addr,
    input  logic [DW-1:0] i_c_wdata,
    output logic          o_c_gnt,
    output logic          o_c_rvalid,
    output logic [DW-1:0] o_c_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic          i_d_lock,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_m_we,
    output logic [AW-1:0] o_m_addr,
    output logic [DW-1:0] o_m_wdata,
    input  logic [DW-1:0] i_m_rdata,
    output logic          o_starved
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef enum logic {ARB, DLOCK} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          c_rv_q, d_rv_q;
    logic          locked, starve_win, d_win, c_win;
    // a locked burst only continues while D keeps both req and lock high
    assign locked     = state_q == DLOCK && i_d_req && i_d_lock;
    assign starve_win = !locked && i_c_req && i_d_req && starve_q == CW'(STARVE_MAX);
    // reset masks every grant so nothing reaches memory while i_rst is high
    assign d_win      = !i_rst && i_d_req && (locked || !i_c_req || starve_win);
    assign c_win      = !i_rst && i_c_req && !d_win;
    assign o_c_gnt    = c_win;
    assign o_d_gnt    = d_win;
    assign o_starved  = !i_rst && starve_win;
    assign o_m_we     = c_win ? i_c_we : d_win && i_d_we;
    assign o_m_addr   = c_win ? i_c_addr : d_win ? i_d_addr : '0;
    assign o_m_wdata  = c_win ? i_c_wdata : d_win ? i_d_wdata : '0;
    assign o_c_rvalid = c_rv_q;
    assign o_d_rvalid = d_rv_q;
    assign o_c_rdata  = c_rv_q ? i_m_rdata : '0;
    assign o_d_rdata  = d_rv_q ? i_m_rdata : '0;
    always_comb begin
        state_d  = (d_win && i_d_lock) ? DLOCK : ARB;
        starve_d = (!i_d_req || d_win) ? '0 :
                   (state_q == ARB && starve_q != CW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ARB;
            starve_q <= '0;
            c_rv_q   <= 1'b0;
            d_rv_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            c_rv_q   <= c_win && !i_c_we;
            d_rv_q   <= d_win && !i_d_we;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a memory model and reference model
module tb_dmem_arbiter;
    localparam int STARVE = 8;
    logic        clk = 1'b0, rst = 1'b1;
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0, d_lock = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, m_we, starved;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [31:0] mem [0:255];
    int          checks = 0, errors = 0;
    int          mw = 0;
    bit          ml = 0, e_crv = 0, e_drv = 0;
    logic [31:0] e_cdat = 0, e_ddat = 0;
    bit          last_cg, last_dg, last_mwe, last_crv;
    logic [31:0] last_cdat;
    bit          rcr = 0, rcw, rdr = 0, rdw, rdl;
    logic [31:0] rca, rcd, rda, rdd;
    typedef struct {bit rst, cr, dr, dl, ec, ed, es;} vec_t;
    vec_t        tbl [$];

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_lock(d_lock), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .i_m_rdata(m_rdata),
        .o_starved(starved)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_we) mem[m_addr[9:2]] <= m_wdata;
        m_rdata <= mem[m_addr[9:2]];
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_starved", starved, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mw = 0; ml = 0; e_crv = 0; e_drv = 0;
    endtask

    // one cycle: drive at negedge, compare against the rule-based model, advance the model
    task automatic step(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                        input bit dr, input bit dw, input bit dl, input logic [31:0] da, input logic [31:0] dd);
        bit lk, sw, ec, ed, ewe;
        logic [31:0] ea, ewd;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
        #1;
        lk  = ml && dr && dl;
        sw  = !lk && cr && dr && mw >= STARVE;
        ed  = dr && (lk || !cr || sw);
        ec  = cr && !ed;
        ewe = ec ? cw : (ed && dw);
        ea  = ec ? ca : ed ? da : 32'd0;
        ewd = ec ? cd : ed ? dd : 32'd0;
        chk("c_gnt", c_gnt, ec);
        chk("d_gnt", d_gnt, ed);
        chk("starved", starved, sw);
        chk("m_we", m_we, ewe);
        chk("m_addr", m_addr, ea);
        chk("m_wdata", m_wdata, ewd);
        chk("c_rvalid", c_rvalid, e_crv);
        chk("c_rdata", c_rdata, e_crv ? e_cdat : 32'd0);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("d_rdata", d_rdata, e_drv ? e_ddat : 32'd0);
        last_cg = c_gnt; last_dg = d_gnt; last_mwe = m_we; last_crv = c_rvalid; last_cdat = c_rdata;
        e_crv  = ec && !cw;
        e_cdat = mem[ca[9:2]];
        e_drv  = ed && !dw;
        e_ddat = mem[da[9:2]];
        mw = (!dr || ed) ? 0 : mw + (ml ? 0 : 1);
        ml = ed && dl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
        mem[4] = 32'hA5A5_A5A5;
        for (int i = 0; i < 8; i++) tbl.push_back('{i == 0, 1, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0});
        for (int i = 0; i < 8; i++) tbl.push_back('{i == 0, 1, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 1});
        for (int i = 0; i < 3; i++) tbl.push_back('{0, 1, 1, 1, 0, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0});
        do_reset();
        // single core read returns preloaded data one cycle later
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        chk("t1_gnt", last_cg, 1);
        idle();
        chk("t1_rvalid", last_crv, 1);
        chk("t1_rdata", last_cdat, 32'hA5A5_A5A5);
        // starvation override and locked burst
        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            step(tbl[k].cr, 0, 32'h40, 0, tbl[k].dr, 1, tbl[k].dl, 32'h80 + k * 4, 32'hD000_0000 + k);
            chk("tbl_c_gnt", last_cg, tbl[k].ec);
            chk("tbl_d_gnt", last_dg, tbl[k].ed);
        end
        // write then read-back
        step(1, 1, 32'h20, 32'h1234_5678, 0, 0, 0, 0, 0);
        chk("t4_we1", last_mwe, 1);
        step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        chk("t4_we0", last_mwe, 0);
        idle();
        chk("t4_rvalid", last_crv, 1);
        chk("t4_rdata", last_cdat, 32'h1234_5678);
        // reset while a read is in flight, with requests still asserted
        step(1, 0, 32'h30, 0, 0, 0, 0, 0, 0);
        c_req = 1; d_req = 1; d_lock = 1;
        do_reset();
        step(1, 0, 32'h30, 0, 1, 1, 1, 32'h90, 32'h55);
        chk("t5_arb_c", last_cg, 1);
        for (int i = 0; i < 5; i++) idle();
        for (int i = 0; i < 9; i++) step(1, 0, 32'h44, 0, 1, 0, 0, 32'h48, 0);
        chk("t6_starve9", last_dg, 1);
        idle();
        // randomized traffic: requesters hold their transaction until granted
        for (int i = 0; i < 600; i++) begin
            if (!rcr || last_cg) begin
                rcr = $urandom_range(0, 3) != 0;
                rcw = 1'($urandom_range(0, 1));
                rca = 32'($urandom_range(0, 255)) << 2;
                rcd = $urandom;
            end
            if (!rdr || last_dg) begin
                rdr = $urandom_range(0, 2) != 0;
                rdw = 1'($urandom_range(0, 1));
                rdl = $urandom_range(0, 3) == 0;
                rda = 32'($urandom_range(0, 255)) << 2;
                rdd = $urandom;
            end
            step(rcr, rcw, rca, rcd, rdr, rdw, rdl, rda, rdd);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
